// File: rtl/mem_writer_if.sv
// Store request and read-port bundle for mem_writer.
// The slave side is the writer; the master side is whoever issues stores and reads.
interface mem_writer_if;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [1:0]  wr_size;
  logic [31:0] rd_addr;
  logic [31:0] rd_data;

  modport slave (
    input  wr_valid, wr_addr, wr_data, wr_size, rd_addr,
    output wr_ready, rd_data
  );

  modport master (
    output wr_valid, wr_addr, wr_data, wr_size, rd_addr,
    input  wr_ready, rd_data
  );
endinterface

// File: rtl/mem_writer.sv
// Buffered store unit: validates byte/half/word stores, queues them in a small FIFO
// and drains one entry per cycle into a word-addressed data array.
module mem_writer #(
  parameter logic [31:0] BASE      = 32'h10010000,
  parameter int          MEM_WORDS = 256,
  parameter int          DEPTH     = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  mem_writer_if.slave bus,
  output logic [2:0]  buf_count,
  output logic        buf_empty,
  output logic        err,
  output logic [7:0]  err_count
);

  localparam int          IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int          PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] SPAN  = 32'(4 * MEM_WORDS);

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [3:0]       be;
    logic [31:0]      data;
  } entry_t;

  entry_t           fifo_q [DEPTH];
  // Array contents survive reset, so they get a power-up value instead of a reset term.
  logic [31:0]      mem_q  [MEM_WORDS] = '{default: '0};

  logic [2:0]       count_q, count_d;
  logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic             err_q, err_d;
  logic [7:0]       err_cnt_q, err_cnt_d;

  logic [31:0]      wr_off, rd_off;
  logic             wr_in_range, align_ok, hs, push, pop, reject;
  logic             rd_in_range;
  entry_t           new_entry;
  logic             unused_rd_bits;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign wr_off      = bus.wr_addr - BASE;
  assign wr_in_range = (bus.wr_addr >= BASE) && (wr_off < SPAN);

  always_comb begin
    align_ok = 1'b0;
    case (bus.wr_size)
      2'b00:   align_ok = 1'b1;
      2'b01:   align_ok = ~wr_off[0];
      2'b10:   align_ok = (wr_off[1:0] == 2'b00);
      default: align_ok = 1'b0;
    endcase
  end

  assign bus.wr_ready = (count_q != 3'(DEPTH));
  assign hs           = bus.wr_valid && bus.wr_ready;
  assign push         = hs && wr_in_range && align_ok;
  assign reject       = hs && !(wr_in_range && align_ok);
  assign pop          = (count_q != 3'd0);

  // Data is replicated across lanes; the byte enables pick the lanes that land.
  always_comb begin
    new_entry.idx  = wr_off[IDX_W+1:2];
    new_entry.be   = 4'b1111;
    new_entry.data = bus.wr_data;
    case (bus.wr_size)
      2'b00: begin
        new_entry.be   = 4'b0001 << wr_off[1:0];
        new_entry.data = {4{bus.wr_data[7:0]}};
      end
      2'b01: begin
        new_entry.be   = wr_off[1] ? 4'b1100 : 4'b0011;
        new_entry.data = {2{bus.wr_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 3'd1;
    else if (!push && pop) count_d = count_q - 3'd1;
    wptr_d    = push ? ptr_inc(wptr_q) : wptr_q;
    rptr_d    = pop  ? ptr_inc(rptr_q) : rptr_q;
    err_d     = reject;
    err_cnt_d = (reject && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count_q   <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      count_q   <= count_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
      if (push) fifo_q[wptr_q] <= new_entry;
    end
  end

  // A drain on a reset edge is suppressed so pending entries are discarded.
  always_ff @(posedge clock) begin
    if (reset_n && pop) begin
      for (int b = 0; b < 4; b++) begin
        if (fifo_q[rptr_q].be[b])
          mem_q[fifo_q[rptr_q].idx][8*b +: 8] <= fifo_q[rptr_q].data[8*b +: 8];
      end
    end
  end

  assign rd_off         = bus.rd_addr - BASE;
  assign rd_in_range    = (bus.rd_addr >= BASE) && (rd_off < SPAN);
  assign bus.rd_data    = rd_in_range ? mem_q[rd_off[IDX_W+1:2]] : 32'h0000_0000;
  assign unused_rd_bits = ^rd_off[1:0];

  assign buf_count = count_q;
  assign buf_empty = (count_q == 3'd0);
  assign err       = err_q;
  assign err_count = err_cnt_q;

endmodule

// File: tb/tb_mem_writer.sv
// Directed bench for mem_writer: lane placement, latency, rejects, range edges,
// reset behaviour and error-count saturation, all against hand-computed values.
module tb_mem_writer;
  logic       clock = 1'b0;
  logic       reset_n;
  logic [2:0] buf_count;
  logic       buf_empty;
  logic       err;
  logic [7:0] err_count;
  int         n_cmp = 0;
  int         n_bad = 0;

  mem_writer_if bus ();

  mem_writer dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .bus       (bus),
    .buf_count (buf_count),
    .buf_empty (buf_empty),
    .err       (err),
    .err_count (err_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    bus.wr_valid = 1'b1;
    bus.wr_addr  = a;
    bus.wr_data  = d;
    bus.wr_size  = s;
  endtask

  task automatic idle();
    bus.wr_valid = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
    bus.rd_addr = a;
    #1;
    check(tag, bus.rd_data, exp);
  endtask

  initial begin
    reset_n     = 1'b0;
    bus.wr_valid = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.wr_size  = '0;
    bus.rd_addr  = 32'h1001_0004;
    tick();
    tick();
    reset_n = 1'b1;
    check("rst_count", 32'(buf_count), 32'd0);
    check("rst_empty", 32'(buf_empty), 32'd1);
    check("rst_ready", 32'(bus.wr_ready), 32'd1);
    check("rst_err", 32'(err), 32'd0);
    check("rst_errcnt", 32'(err_count), 32'd0);
    rd_check("rst_mem0", 32'h1001_0004, 32'h0);

    // Word store latency
    store(32'h1001_0004, 32'hDEAD_BEEF, 2'b10);
    tick();
    idle();
    check("word_count_N", 32'(buf_count), 32'd1);
    check("word_empty_N", 32'(buf_empty), 32'd0);
    rd_check("word_not_yet", 32'h1001_0004, 32'h0);
    tick();
    rd_check("word_landed", 32'h1001_0004, 32'hDEAD_BEEF);
    check("word_empty_N1", 32'(buf_empty), 32'd1);

    // Byte lane 1 then upper half, then lower half
    store(32'h1001_0009, 32'hFFFF_FFAA, 2'b00);
    tick();
    store(32'h1001_000A, 32'hFFFF_1234, 2'b01);
    tick();
    idle();
    tick();
    rd_check("byte_half", 32'h1001_0008, 32'h1234_AA00);
    store(32'h1001_0008, 32'h0000_5678, 2'b01);
    tick();
    idle();
    tick();
    rd_check("half_low", 32'h1001_0008, 32'h1234_5678);

    // Five back-to-back word stores
    for (int i = 0; i < 5; i++) begin
      store(32'h1001_0010 + 32'(4 * i), 32'hA000_0000 + 32'(i), 2'b10);
      tick();
      check("b2b_count", 32'(buf_count), 32'd1);
      check("b2b_ready", 32'(bus.wr_ready), 32'd1);
    end
    idle();
    tick();
    check("b2b_empty", 32'(buf_empty), 32'd1);
    for (int i = 0; i < 5; i++)
      rd_check("b2b_data", 32'h1001_0010 + 32'(4 * i), 32'hA000_0000 + 32'(i));

    // Four rejected stores
    tick();
    store(32'h1001_0001, 32'h0000_1111, 2'b01);
    tick();
    check("rej_half_err", 32'(err), 32'd1);
    store(32'h1001_0002, 32'h2222_2222, 2'b10);
    tick();
    check("rej_word_err", 32'(err), 32'd1);
    store(32'h1001_0010, 32'h3333_3333, 2'b11);
    tick();
    check("rej_size_err", 32'(err), 32'd1);
    store(32'h1000_0000, 32'h0000_0044, 2'b00);
    tick();
    check("rej_low_err", 32'(err), 32'd1);
    check("rej_count", 32'(buf_count), 32'd0);
    idle();
    tick();
    check("rej_err_clr", 32'(err), 32'd0);
    check("rej_errcnt", 32'(err_count), 32'd4);
    rd_check("rej_mem0", 32'h1001_0000, 32'h0);
    rd_check("rej_mem10", 32'h1001_0010, 32'hA000_0000);

    // Upper range edge
    store(32'h1001_03FC, 32'h55AA_55AA, 2'b10);
    tick();
    check("last_ok_err", 32'(err), 32'd0);
    check("last_ok_count", 32'(buf_count), 32'd1);
    store(32'h1001_0400, 32'h7777_7777, 2'b10);
    tick();
    check("past_end_err", 32'(err), 32'd1);
    idle();
    tick();
    check("past_end_errcnt", 32'(err_count), 32'd5);
    rd_check("last_word", 32'h1001_03FF, 32'h55AA_55AA);
    rd_check("rd_past_end", 32'h1001_0400, 32'h0);
    rd_check("rd_below", 32'h1000_FFFC, 32'h0);

    // Reset with a pending entry, and a store presented during reset
    store(32'h1001_0030, 32'h1111_1111, 2'b10);
    tick();
    store(32'h1001_0034, 32'h2222_2222, 2'b10);
    tick();
    store(32'h1001_0038, 32'h3333_3333, 2'b10);
    tick();
    check("pre_rst_count", 32'(buf_count), 32'd1);
    reset_n = 1'b0;
    store(32'h1001_0040, 32'h4444_4444, 2'b11);
    tick();
    check("mid_rst_count", 32'(buf_count), 32'd0);
    check("mid_rst_empty", 32'(buf_empty), 32'd1);
    check("mid_rst_ready", 32'(bus.wr_ready), 32'd1);
    check("mid_rst_errcnt", 32'(err_count), 32'd0);
    reset_n = 1'b1;
    idle();
    tick();
    check("post_rst_err", 32'(err), 32'd0);
    check("post_rst_errcnt", 32'(err_count), 32'd0);
    rd_check("rst_keep30", 32'h1001_0030, 32'h1111_1111);
    rd_check("rst_keep34", 32'h1001_0034, 32'h2222_2222);
    rd_check("rst_drop38", 32'h1001_0038, 32'h0);
    rd_check("rst_keep04", 32'h1001_0004, 32'hDEAD_BEEF);

    // Error counter saturation
    store(32'h1001_0000, 32'h0, 2'b11);
    for (int i = 1; i <= 256; i++) begin
      tick();
      if (i == 254) check("sat_254", 32'(err_count), 32'd254);
      if (i == 255) check("sat_255", 32'(err_count), 32'd255);
    end
    check("sat_256", 32'(err_count), 32'd255);
    check("sat_err", 32'(err), 32'd1);
    idle();
    tick();
    check("sat_err_clr", 32'(err), 32'd0);
    check("sat_hold", 32'(err_count), 32'd255);
    rd_check("sat_mem0", 32'h1001_0000, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
